// File: rtl/onehot_scan_encoder_pkg.sv
// ---------------------------------------------------------------------------
// onehot_scan_encoder_pkg
// Shared widths and state encoding for the one-hot scan encoder.
//   VEC_W : width of the accepted bit vector
//   IDX_W : width of an emitted bit index
//   CNT_W : width of the population count (must hold 0..VEC_W)
//   state_t : controller states IDLE / SCAN
// ---------------------------------------------------------------------------
package onehot_scan_encoder_pkg;

    localparam int VEC_W = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/onehot_scan_encoder_if.sv
// ---------------------------------------------------------------------------
// onehot_scan_encoder_if
// Bundles the upstream vector handshake and the downstream index stream.
//   in_valid / in_data / in_ready          : vector input handshake
//   out_valid / out_ready                  : index beat handshake
//   out_addr / out_last / out_count        : beat payload
//   zero_err                               : pulse on all-zero vector accept
// Modports: slave (the encoder), master (the environment driving it).
// ---------------------------------------------------------------------------
interface onehot_scan_encoder_if;
    import onehot_scan_encoder_pkg::*;

    logic             in_valid;
    logic [VEC_W-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_addr;
    logic             out_last;
    logic [CNT_W-1:0] out_count;
    logic             zero_err;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_addr, out_last, out_count, zero_err
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_addr, out_last, out_count, zero_err
    );

endinterface

// File: rtl/onehot_scan_encoder_lsb_prienc.sv
// ---------------------------------------------------------------------------
// lsb_prienc
// Combinational lowest-set-bit priority encoder.
//   i_vec     : input vector
//   o_idx     : index of the lowest set bit (0 when i_vec is zero)
//   o_one_hot : exactly one bit of i_vec is set
// ---------------------------------------------------------------------------
module lsb_prienc
    import onehot_scan_encoder_pkg::*;
(
    input  logic [VEC_W-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_one_hot
);

    // Walk from the top down so the lowest set bit is the last to write.
    always_comb begin
        o_idx = '0;
        for (int i = VEC_W - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    // v & (v-1) clears the lowest set bit; zero result means at most one bit.
    always_comb begin
        o_one_hot = (i_vec != '0) && ((i_vec & (i_vec - VEC_W'(1))) == '0);
    end

endmodule

// File: rtl/onehot_scan_encoder.sv
// ---------------------------------------------------------------------------
// onehot_scan_encoder
// Accepts an 8-bit vector and emits the index of every set bit, lowest
// first, one beat per out_valid/out_ready handshake.
//   clk   : clock, rising-edge
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of onehot_scan_encoder_if
//           (vector handshake in, index stream + count + zero_err out)
// ---------------------------------------------------------------------------
module onehot_scan_encoder
    import onehot_scan_encoder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    onehot_scan_encoder_if.slave  bus
);

    state_t           r_state;
    state_t           w_next;
    logic [VEC_W-1:0] r_pend;
    logic [CNT_W-1:0] r_count;
    logic             r_zero_err;

    logic [IDX_W-1:0] w_idx;
    logic             w_one_hot;
    logic             w_accept;
    logic             w_hs;

    function automatic logic [CNT_W-1:0] popcount(input logic [VEC_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < VEC_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    lsb_prienc u_prienc (
        .i_vec     (r_pend),
        .o_idx     (w_idx),
        .o_one_hot (w_one_hot)
    );

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_hs     = (r_state == SCAN) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_addr  = '0;
        bus.out_last  = 1'b0;
        unique case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                // An all-zero vector has nothing to emit, so stay idle.
                if (bus.in_valid && (bus.in_data != '0)) begin
                    w_next = SCAN;
                end
            end
            SCAN: begin
                bus.out_valid = 1'b1;
                bus.out_addr  = w_idx;
                bus.out_last  = w_one_hot;
                if (bus.out_ready && w_one_hot) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Pending bits, burst count and the zero-vector flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= '0;
            r_count    <= '0;
            r_zero_err <= 1'b0;
        end else begin
            r_zero_err <= w_accept && (bus.in_data == '0);
            if (w_accept) begin
                r_pend  <= bus.in_data;
                r_count <= popcount(bus.in_data);
            end else if (w_hs) begin
                r_pend <= r_pend & ~(VEC_W'(1) << w_idx);
            end
        end
    end

    assign bus.out_count = r_count;
    assign bus.zero_err  = r_zero_err;

endmodule
